// File: rtl/ram_check_pkg.sv
// Shared FSM state type and encoding for the RAM read checker.
// Used by ram_read_checker and ram_addr_gen.
package ram_check_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ENC_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ENC_READ  = 2'd1;
    localparam logic [STATE_W-1:0] ENC_DRAIN = 2'd2;
    localparam logic [STATE_W-1:0] ENC_DONE  = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_READ  = ENC_READ,
        ST_DRAIN = ENC_DRAIN,
        ST_DONE  = ENC_DONE
    } state_e;

endpackage

// File: rtl/ram_addr_gen.sv
// Loadable, enabled read-address counter with a last-address flag.
// The counter parks on LAST_ADDR instead of wrapping.
module ram_addr_gen
    import ram_check_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = 2**ADDR_W-1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = '0;
        end else if (en_i && !last_o) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (addr_q == LAST_A);

endmodule

// File: rtl/ram_read_checker.sv
// Sweeps a synchronous RAM and checks data==address at every location.
// Define RAM_CHECK_ERR_CAPTURE_EN to latch the first mismatch address/data.
module ram_read_checker
    import ram_check_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 2**ADDR_W-1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  err_cnt_d;
    logic              cmp_vld_q;
    logic [ADDR_W-1:0] cmp_addr_q;

    logic              start_acc;
    logic              addr_last;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    assign start_acc = (state_q == ST_IDLE) && start;

    ram_addr_gen #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start_acc),
        .en_i   (state_q == ST_READ),
        .addr_o (ram_addr),
        .last_o (addr_last)
    );

    // Read data lags the issued address by one cycle.
    assign exp_data = DATA_W'(cmp_addr_q);
    assign mismatch = cmp_vld_q && (ram_rdata != exp_data);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start_acc) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            cmp_vld_q  <= rd_en_q;
            cmp_addr_q <= ram_addr;
            done_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (addr_last) begin
                        state_q <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Last compare lands on this edge, so use the next count.
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_d == '0);
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAM_CHECK_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] ferr_addr_q;
    logic [DATA_W-1:0] ferr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
        end else if (start_acc) begin
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
        end else if (mismatch && (err_cnt_q == '0)) begin
            ferr_addr_q <= cmp_addr_q;
            ferr_data_q <= ram_rdata;
        end
    end

    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
`else
    assign first_err_addr = '0;
    assign first_err_data = '0;
`endif

    assign ram_rd_en = rd_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ram_read_checker.sv
// Directed bench for ram_read_checker (ADDR_W=4, DATA_W=8, LAST_ADDR=15).
// Cycle 1 is the cycle after the start edge, so done shows after edge 17.
module tb_ram_read_checker;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LA = 15;
    localparam int DONE_EDGES = LA + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;

    always #5 clk = ~clk;

    logic          rd_en, busy, done, pass;
    logic [AW-1:0] addr, fea;
    logic [DW-1:0] rdata, fed;
    logic [7:0]    errc;

    logic          rd_en2, busy2, done2, pass2;
    logic [AW-1:0] addr2, fea2;
    logic [DW-1:0] rdata2, fed2;
    logic [2:0]    errc2;

    logic [DW-1:0] mem  [16];
    logic [DW-1:0] mem2 [16];

    ram_read_checker #(
        .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LA), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_rd_en(rd_en), .ram_addr(addr), .ram_rdata(rdata),
        .busy(busy), .done(done), .pass(pass), .err_count(errc),
        .first_err_addr(fea), .first_err_data(fed)
    );

    ram_read_checker #(
        .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LA), .CNT_W(3)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .ram_rd_en(rd_en2), .ram_addr(addr2), .ram_rdata(rdata2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(errc2),
        .first_err_addr(fea2), .first_err_data(fed2)
    );

    always @(posedge clk) begin
        if (rd_en) rdata <= mem[addr];
        if (rd_en2) rdata2 <= mem2[addr2];
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int base, output int lat,
                             output logic rd_drain);
        lat = base;
        rd_drain = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (lat == DONE_EDGES - 1) rd_drain = rd_en;
            if (done) break;
        end
    endtask

    int   lat;
    logic rdd;
    logic seen;
    logic [AW-1:0] exp_fa;
    logic [DW-1:0] exp_fd;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]  = DW'(i);
            mem2[i] = ~DW'(i);
        end
`ifdef RAM_CHECK_ERR_CAPTURE_EN
        exp_fa = 4'd5;
        exp_fd = 8'hFF;
`else
        exp_fa = 4'd0;
        exp_fd = 8'h00;
`endif
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", errc, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_addr", addr, 0);
        check("rst_fea", fea, 0);
        check("rst_fed", fed, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean sweep.
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_rd_en", rd_en, 1);
        check("t1_addr0", addr, 0);
        wait_done(0, lat, rdd);
        check("t1_latency", lat, DONE_EDGES);
        check("t1_drain_rd_en", rdd, 0);
        check("t1_pass", pass, 1);
        check("t1_err", errc, 0);
        check("t1_busy_done", busy, 1);
        @(posedge clk);
        #1;
        check("t1_done_drop", done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_pass_hold", pass, 1);

        // Single corrupted location.
        mem[5] = 8'hFF;
        pulse_start();
        wait_done(0, lat, rdd);
        check("t2_latency", lat, DONE_EDGES);
        check("t2_pass", pass, 0);
        check("t2_err", errc, 1);
        check("t2_fea", fea, exp_fa);
        check("t2_fed", fed, exp_fd);
        mem[5] = 8'h05;

        // Start in the IDLE cycle right after DONE.
        @(posedge clk);
        #1;
        check("t3_idle", busy, 0);
        check("t3_err_hold", errc, 1);
        check("t3_pass_hold", pass, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_err_clr", errc, 0);
        check("t3_fea_clr", fea, 0);
        wait_done(0, lat, rdd);
        check("t3_latency", lat, DONE_EDGES);
        check("t3_pass", pass, 1);

        // Start while busy is ignored.
        @(posedge clk);
        #1;
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check("t4_addr4", addr, 4);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("t4_no_restart", addr, 5);
        wait_done(5, lat, rdd);
        check("t4_latency", lat, DONE_EDGES);
        check("t4_pass", pass, 1);

        // Reset in the middle of a sweep.
        @(posedge clk);
        #1;
        pulse_start();
        repeat (7) @(posedge clk);
        #1;
        check("t5_addr7", addr, 7);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_en", rd_en, 0);
        check("t5_rst_addr", addr, 0);
        check("t5_rst_err", errc, 0);
        check("t5_rst_pass", pass, 0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        check("t5_no_done", seen, 0);
        check("t5_idle", busy, 0);
        pulse_start();
        wait_done(0, lat, rdd);
        check("t5_latency", lat, DONE_EDGES);
        check("t5_pass", pass, 1);
        check("t5_err", errc, 0);

        // Saturating counter, every location corrupted.
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (done2) break;
        end
        check("t6_latency", lat, DONE_EDGES);
        check("t6_err_sat", errc2, 7);
        check("t6_pass", pass2, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
